bitrev_reader: RTL

BITREV_READER -- requirements
Module: bitrev_reader

---
 rtl/fft_pkg.sv | 27 ++
 rtl/bitrev_ram.sv | 40 ++++
 rtl/bitrev_reader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, frame-buffer state encoding and bit-reverse helper.
// Rev 1.0
`default_nettype none

package fft_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_LOG2N = 12;
   localparam int MIN_LOG2N     = 3;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Reverse the low n bits of j; bits at or above n come out as zero.
   function automatic logic [15:0] bit_reverse(input logic [15:0] j, input logic [3:0] n);
      logic [15:0] full;
      for (int i = 0; i < 16; i++) begin
         full[15 - i] = j[i];
      end
      return full >> (5'd16 - {1'b0, n});
   endfunction

endpackage

`default_nettype wire

// File: rtl/bitrev_ram.sv
// bitrev_ram: simple dual-port buffer, synchronous write, registered read with enable.
// Rev 1.0
`default_nettype none

module bitrev_ram
   import fft_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_MAX_LOG2N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the output register is reset; array contents are left as-is.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/bitrev_reader.sv
// bitrev_reader: accepts a frame of N samples in natural order, emits it bit-reversed.
// Rev 1.0
`default_nettype none

module bitrev_reader
   import fft_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_LOG2N = DEF_MAX_LOG2N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [3:0]        log2n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              o_last,
   output logic              busy
);

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           lg;
   logic [3:0]           lg_clamped;
   logic [MAX_LOG2N-1:0] wr_cnt;
   logic [MAX_LOG2N-1:0] rd_cnt;
   logic [MAX_LOG2N-1:0] last_idx;
   logic [MAX_LOG2N-1:0] rd_addr;
   logic                 rd_done;
   logic                 drain_go;
   logic                 valid_q;
   logic                 last_q;
   logic                 in_xfer;
   logic                 out_xfer;
   logic                 rd_issue;
   logic                 frame_in_done;
   logic                 frame_out_done;

   always_comb begin
      lg_clamped = log2n;
      if (log2n < 4'(MIN_LOG2N)) begin
         lg_clamped = 4'(MIN_LOG2N);
      end else if (log2n > 4'(MAX_LOG2N)) begin
         lg_clamped = 4'(MAX_LOG2N);
      end
   end

   assign last_idx       = {MAX_LOG2N{1'b1}} >> (4'(MAX_LOG2N) - lg);
   assign rd_addr        = MAX_LOG2N'(bit_reverse(16'(rd_cnt), lg));
   assign in_xfer        = i_valid & i_ready;
   assign out_xfer       = o_valid & o_ready;
   assign frame_in_done  = in_xfer & (wr_cnt == last_idx);
   assign frame_out_done = out_xfer & last_q;
   // drain_go inserts one idle cycle so the final write settles before the first read.
   assign rd_issue       = (state == DRAIN) & drain_go & ~rd_done & ce & (~valid_q | o_ready);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (frame_in_done)  state_nxt = DRAIN;
         DRAIN:   if (frame_out_done) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      i_ready = (state == FILL) & ce;
      busy    = (state == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lg       <= lg_clamped;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         rd_done  <= 1'b0;
         drain_go <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
      end else if (ce) begin
         if (in_xfer) begin
            wr_cnt <= frame_in_done ? '0 : wr_cnt + 1'b1;
         end
         if ((state == DRAIN) && !drain_go) begin
            drain_go <= 1'b1;
         end
         if (rd_issue) begin
            rd_cnt  <= (rd_cnt == last_idx) ? '0 : rd_cnt + 1'b1;
            valid_q <= 1'b1;
            last_q  <= (rd_cnt == last_idx);
            if (rd_cnt == last_idx) begin
               rd_done <= 1'b1;
            end
         end else if (out_xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
         if (frame_out_done) begin
            lg       <= lg_clamped;
            rd_done  <= 1'b0;
            drain_go <= 1'b0;
         end
      end
   end

   assign o_valid = valid_q & ce;
   assign o_last  = last_q;

   bitrev_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (MAX_LOG2N)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (in_xfer),
      .waddr (wr_cnt),
      .wdata (i_data),
      .re    (rd_issue),
      .raddr (rd_addr),
      .rdata (o_data)
   );

endmodule

`default_nettype wire
